// File: rtl/dsp_mac_slice_if.sv
// Sample-stream bundle for dsp_mac_slice.
//   master: drives control and operands (ce, clr, in_valid, a, b, d, c, mode),
//           observes the result (p, out_valid, out_last, ovf).
//   slave : the MAC slice itself.
interface dsp_mac_slice_if #(
  parameter int unsigned A_WIDTH = 18,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned P_WIDTH = 48
);
  logic                      ce;
  logic                      clr;
  logic                      in_valid;
  logic signed [A_WIDTH-1:0] a;
  logic signed [B_WIDTH-1:0] b;
  logic signed [B_WIDTH-1:0] d;
  logic signed [P_WIDTH-1:0] c;
  logic [2:0]                mode;
  logic signed [P_WIDTH-1:0] p;
  logic                      out_valid;
  logic                      out_last;
  logic                      ovf;

  modport master (
    output ce, clr, in_valid, a, b, d, c, mode,
    input  p, out_valid, out_last, ovf
  );

  modport slave (
    input  ce, clr, in_valid, a, b, d, c, mode,
    output p, out_valid, out_last, ovf
  );
endinterface

// File: rtl/dsp_mac_slice.sv
// Signed pre-add / multiply / post-add MAC slice with accumulate-and-dump.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - dsp_mac_slice_if.slave: ce (stall when 0), clr (flush, beats ce),
//           in_valid, a, b, d, c, mode[0]=presub, mode[1]=use_preadd, mode[2]=acc;
//           p, out_valid, out_last, ovf
// Pipeline: in regs -> pre-adder reg -> product (reg when MREG=1) -> P.
module dsp_mac_slice #(
  parameter int unsigned A_WIDTH  = 18,
  parameter int unsigned B_WIDTH  = 18,
  parameter int unsigned P_WIDTH  = 48,
  parameter int unsigned MREG     = 1,
  parameter int unsigned ACC_LEN  = 16,
  parameter int unsigned SATURATE = 1
) (
  input logic            clk,
  input logic            rst_n,
  dsp_mac_slice_if.slave bus
);

  localparam int unsigned PreW = B_WIDTH + 1;
  localparam int unsigned MulW = A_WIDTH + B_WIDTH + 1;
  localparam int unsigned SumW = P_WIDTH + 1;
  localparam int unsigned CntW = $clog2(ACC_LEN);

  localparam logic [CntW-1:0]         LastCnt = CntW'(ACC_LEN - 1);
  localparam logic signed [P_WIDTH-1:0] PMax  = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] PMin  = {1'b1, {(P_WIDTH-1){1'b0}}};

  if (P_WIDTH < MulW) begin : g_bad_p_width
    $fatal(1, "dsp_mac_slice: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end
  if (ACC_LEN < 2) begin : g_bad_acc_len
    $fatal(1, "dsp_mac_slice: ACC_LEN must be >= 2");
  end
  if (MREG > 1) begin : g_bad_mreg
    $fatal(1, "dsp_mac_slice: MREG must be 0 or 1");
  end

  // ---------------- Stage 1: input registers ----------------
  logic signed [A_WIDTH-1:0] a1_q;
  logic signed [B_WIDTH-1:0] b1_q, d1_q;
  logic signed [P_WIDTH-1:0] c1_q;
  logic [2:0]                mode1_q;
  logic                      vld1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q    <= '0;
      b1_q    <= '0;
      d1_q    <= '0;
      c1_q    <= '0;
      mode1_q <= '0;
      vld1_q  <= 1'b0;
    end else if (bus.clr) begin
      vld1_q <= 1'b0;
    end else if (bus.ce) begin
      a1_q    <= bus.a;
      b1_q    <= bus.b;
      d1_q    <= bus.d;
      c1_q    <= bus.c;
      mode1_q <= bus.mode;
      vld1_q  <= bus.in_valid;
    end
  end

  // ---------------- Stage 2: pre-adder ----------------
  logic signed [PreW-1:0] b_ext, d_ext, pre_d;

  always_comb begin
    b_ext = {b1_q[B_WIDTH-1], b1_q};
    d_ext = {d1_q[B_WIDTH-1], d1_q};
    if (mode1_q[1]) begin
      pre_d = mode1_q[0] ? (d_ext - b_ext) : (d_ext + b_ext);
    end else begin
      pre_d = b_ext;
    end
  end

  logic signed [A_WIDTH-1:0] a2_q;
  logic signed [PreW-1:0]    pre2_q;
  logic signed [P_WIDTH-1:0] c2_q;
  logic                      acc2_q;
  logic                      vld2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2_q   <= '0;
      pre2_q <= '0;
      c2_q   <= '0;
      acc2_q <= 1'b0;
      vld2_q <= 1'b0;
    end else if (bus.clr) begin
      vld2_q <= 1'b0;
    end else if (bus.ce) begin
      a2_q   <= a1_q;
      pre2_q <= pre_d;
      c2_q   <= c1_q;
      acc2_q <= mode1_q[2];
      vld2_q <= vld1_q;
    end
  end

  // ---------------- Stage 3: multiplier ----------------
  logic signed [MulW-1:0] a_ext, pre_ext, prod;

  always_comb begin
    a_ext   = {{(MulW-A_WIDTH){a2_q[A_WIDTH-1]}}, a2_q};
    pre_ext = {{(MulW-PreW){pre2_q[PreW-1]}}, pre2_q};
    prod    = a_ext * pre_ext;  // full-width result fits exactly in MulW bits
  end

  // Stage-4 operands, either from the product register or straight from stage 2.
  logic signed [MulW-1:0]    m_s4;
  logic signed [P_WIDTH-1:0] c_s4;
  logic                      acc_s4;
  logic                      vld_s4;

  if (MREG != 0) begin : g_mreg
    logic signed [MulW-1:0]    m3_q;
    logic signed [P_WIDTH-1:0] c3_q;
    logic                      acc3_q;
    logic                      vld3_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m3_q   <= '0;
        c3_q   <= '0;
        acc3_q <= 1'b0;
        vld3_q <= 1'b0;
      end else if (bus.clr) begin
        vld3_q <= 1'b0;
      end else if (bus.ce) begin
        m3_q   <= prod;
        c3_q   <= c2_q;
        acc3_q <= acc2_q;
        vld3_q <= vld2_q;
      end
    end

    assign m_s4   = m3_q;
    assign c_s4   = c3_q;
    assign acc_s4 = acc3_q;
    assign vld_s4 = vld3_q;
  end else begin : g_no_mreg
    assign m_s4   = prod;
    assign c_s4   = c2_q;
    assign acc_s4 = acc2_q;
    assign vld_s4 = vld2_q;
  end

  // ---------------- Stage 4: post-adder / accumulator ----------------
  // P doubles as the accumulator, so a saturated running sum keeps
  // accumulating from the clamped value.
  logic signed [P_WIDTH-1:0] p_q, p_d, res;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic signed [SumW-1:0]    m_ext, addend, sum;
  logic                      block_start, ovf_now;

  always_comb begin
    block_start = (cnt_q == '0);
    m_ext       = {{(SumW-MulW){m_s4[MulW-1]}}, m_s4};
    if (acc_s4 && !block_start) begin
      addend = {p_q[P_WIDTH-1], p_q};
    end else begin
      addend = {c_s4[P_WIDTH-1], c_s4};
    end
    sum     = m_ext + addend;
    // Out of P range exactly when the two top bits of the wide sum differ.
    ovf_now = sum[SumW-1] ^ sum[SumW-2];
    if (ovf_now && (SATURATE != 0)) begin
      res = sum[SumW-1] ? PMin : PMax;
    end else begin
      res = sum[P_WIDTH-1:0];
    end

    p_d         = p_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    if (vld_s4) begin
      p_d = res;
      if (acc_s4) begin
        ovf_d = (block_start ? 1'b0 : ovf_q) | ovf_now;
        if (cnt_q == LastCnt) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        // A plain sample also aborts any partially built block.
        ovf_d       = ovf_now;
        cnt_d       = '0;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (bus.clr) begin
      p_q         <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (bus.ce) begin
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end else begin
      // Stalled: result and flag hold, but the valid pulse must not repeat.
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Bench for dsp_mac_slice: two instances share one stimulus stream
//   u_dut_s: MREG=1, SATURATE=1, ACC_LEN=4
//   u_dut_w: MREG=0, SATURATE=0, ACC_LEN=4
// Each instance is compared every cycle against a sample-level model.
module tb_dsp_mac_slice;

  localparam int unsigned AW     = 18;
  localparam int unsigned BW     = 18;
  localparam int unsigned PW     = 48;
  localparam int          AccLen = 4;
  localparam longint      PMax   = (64'sd1 <<< 47) - 64'sd1;
  localparam longint      PMin   = -(64'sd1 <<< 47);
  localparam longint      Span   = 64'sd1 <<< 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsp_mac_slice_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus_s ();
  dsp_mac_slice_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus_w ();

  dsp_mac_slice #(
    .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MREG(1), .ACC_LEN(AccLen), .SATURATE(1)
  ) u_dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s)
  );

  dsp_mac_slice #(
    .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MREG(0), .ACC_LEN(AccLen), .SATURATE(0)
  ) u_dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w)
  );

  typedef struct {
    bit       vld;
    longint   a;
    longint   b;
    longint   d;
    longint   c;
    bit [2:0] mode;
  } smp_t;

  // Per instance: fixed-latency delay line plus observable result state.
  smp_t   line [2][3];
  longint mp    [2];
  bit     movf  [2];
  bit     mval  [2];
  bit     mlast [2];
  int     mcnt  [2];

  int n_vec = 0;
  int n_err = 0;

  bit       cur_ce, cur_clr, cur_iv;
  longint   cur_a, cur_b, cur_d, cur_c;
  bit [2:0] cur_mode;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mp[k] = 0; movf[k] = 0; mval[k] = 0; mlast[k] = 0; mcnt[k] = 0;
      for (int i = 0; i < 3; i++) line[k][i].vld = 1'b0;
    end
  endfunction

  // Apply one finished sample to instance k's result state.
  function automatic void model_result(input int k, input smp_t s);
    longint pre, m, base, sum;
    bit     ov;
    bit     sat;
    mval[k]  = 1'b0;
    mlast[k] = 1'b0;
    if (!s.vld) return;
    sat  = (k == 0);
    pre  = s.mode[1] ? (s.mode[0] ? s.d - s.b : s.d + s.b) : s.b;
    m    = s.a * pre;
    base = (s.mode[2] && mcnt[k] != 0) ? mp[k] : s.c;
    sum  = m + base;
    ov   = (sum > PMax) || (sum < PMin);
    if (sum > PMax) sum = sat ? PMax : sum - Span;
    else if (sum < PMin) sum = sat ? PMin : sum + Span;
    mp[k] = sum;
    if (s.mode[2]) begin
      movf[k] = ((mcnt[k] == 0) ? 1'b0 : movf[k]) | ov;
      if (mcnt[k] == AccLen - 1) begin
        mcnt[k] = 0; mval[k] = 1'b1; mlast[k] = 1'b1;
      end else begin
        mcnt[k] = mcnt[k] + 1;
      end
    end else begin
      movf[k] = ov; mcnt[k] = 0; mval[k] = 1'b1;
    end
  endfunction

  // One rising edge: latency is 3+MREG enabled edges including the accepting one.
  function automatic void model_edge(input int k);
    int   depth;
    smp_t oldest;
    depth = (k == 0) ? 3 : 2;
    if (!rst_n) begin
      mp[k] = 0; movf[k] = 0; mval[k] = 0; mlast[k] = 0; mcnt[k] = 0;
      for (int i = 0; i < 3; i++) line[k][i].vld = 1'b0;
    end else if (cur_clr) begin
      mp[k] = 0; movf[k] = 0; mval[k] = 0; mlast[k] = 0; mcnt[k] = 0;
      for (int i = 0; i < 3; i++) line[k][i].vld = 1'b0;
    end else if (cur_ce) begin
      oldest = line[k][depth-1];
      for (int i = depth - 1; i > 0; i--) line[k][i] = line[k][i-1];
      line[k][0] = '{vld: cur_iv, a: cur_a, b: cur_b, d: cur_d, c: cur_c, mode: cur_mode};
      model_result(k, oldest);
    end else begin
      mval[k] = 1'b0; mlast[k] = 1'b0;
    end
  endfunction

  task automatic drive();
    bus_s.ce = cur_ce;  bus_s.clr = cur_clr;  bus_s.in_valid = cur_iv;
    bus_s.a = cur_a[AW-1:0];  bus_s.b = cur_b[BW-1:0];  bus_s.d = cur_d[BW-1:0];
    bus_s.c = cur_c[PW-1:0];  bus_s.mode = cur_mode;
    bus_w.ce = cur_ce;  bus_w.clr = cur_clr;  bus_w.in_valid = cur_iv;
    bus_w.a = cur_a[AW-1:0];  bus_w.b = cur_b[BW-1:0];  bus_w.d = cur_d[BW-1:0];
    bus_w.c = cur_c[PW-1:0];  bus_w.mode = cur_mode;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_val("s_p", bus_s.p, mp[0]);
    check_val("s_valid", bus_s.out_valid, mval[0]);
    check_val("s_last", bus_s.out_last, mlast[0]);
    check_val("s_ovf", bus_s.ovf, movf[0]);
    check_val("w_p", bus_w.p, mp[1]);
    check_val("w_valid", bus_w.out_valid, mval[1]);
    check_val("w_last", bus_w.out_last, mlast[1]);
    check_val("w_ovf", bus_w.ovf, movf[1]);
  endtask

  task automatic issue(input longint a, input longint b, input longint d, input longint c,
                       input bit [2:0] mode);
    cur_ce = 1'b1; cur_clr = 1'b0; cur_iv = 1'b1;
    cur_a = a; cur_b = b; cur_d = d; cur_c = c; cur_mode = mode;
    drive();
    step();
  endtask

  task automatic go_idle();
    cur_ce = 1'b1; cur_clr = 1'b0; cur_iv = 1'b0;
    drive();
  endtask

  // Run until both instances pulse out_valid (bounded), then check that result.
  task automatic wait_both(input string tag, input longint ps, input longint pw,
                           input bit last, input bit ovf);
    bit seen_s, seen_w;
    logic signed [63:0] cps, cpw, cls, clw, cos, cow;
    seen_s = 0; seen_w = 0;
    cps = 0; cpw = 0; cls = 0; clw = 0; cos = 0; cow = 0;
    go_idle();
    for (int i = 0; i < 12 && !(seen_s && seen_w); i++) begin
      step();
      if (!seen_s && bus_s.out_valid) begin
        seen_s = 1; cps = bus_s.p; cls = bus_s.out_last; cos = bus_s.ovf;
      end
      if (!seen_w && bus_w.out_valid) begin
        seen_w = 1; cpw = bus_w.p; clw = bus_w.out_last; cow = bus_w.ovf;
      end
    end
    check_val({tag, "_seen_s"}, seen_s, 1);
    check_val({tag, "_seen_w"}, seen_w, 1);
    check_val({tag, "_p_s"}, cps, ps);
    check_val({tag, "_p_w"}, cpw, pw);
    check_val({tag, "_last_s"}, cls, last);
    check_val({tag, "_last_w"}, clw, last);
    check_val({tag, "_ovf_s"}, cos, ovf);
    check_val({tag, "_ovf_w"}, cow, ovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [AW-1:0] ra;
    logic signed [BW-1:0] rb, rd;
    logic signed [PW-1:0] rc;

    rst_n = 1'b0;
    cur_ce = 0; cur_clr = 0; cur_iv = 0;
    cur_a = 0; cur_b = 0; cur_d = 0; cur_c = 0; cur_mode = 0;
    model_reset();
    drive();
    step();
    step();
    rst_n = 1'b1;
    go_idle();
    step();

    // Plain multiply-add, then pre-subtract and pre-add.
    issue(3, 4, 0, 10, 3'b000);
    wait_both("basic", 22, 22, 0, 0);
    issue(-2, 4, 10, 0, 3'b011);
    wait_both("presub", -12, -12, 0, 0);
    issue(-2, 4, 10, 0, 3'b010);
    wait_both("preadd", -28, -28, 0, 0);

    // Accumulate-and-dump with block bias, then a second block.
    for (int i = 1; i <= 4; i++) issue(i, 1, 0, 100, 3'b100);
    wait_both("acc1", 110, 110, 1, 0);
    for (int i = 0; i < 4; i++) issue(1, 1, 0, 0, 3'b100);
    wait_both("acc2", 4, 4, 1, 0);

    // Positive overflow: clamp versus wrap.
    issue(1, 1, 0, PMax, 3'b000);
    wait_both("ovf", PMax, PMin, 0, 1);

    // Block aborted by a plain sample, then a fresh block from its own bias.
    issue(1, 1, 0, 7, 3'b100);
    issue(1, 1, 0, 7, 3'b100);
    issue(5, 1, 0, 0, 3'b000);
    wait_both("abort", 5, 5, 0, 0);
    for (int i = 0; i < 4; i++) issue(1, 1, 0, 20, 3'b100);
    wait_both("after_abort", 24, 24, 1, 0);

    // Stall with a valid-looking sample presented: it must be dropped.
    issue(2, 3, 0, 1, 3'b000);
    cur_ce = 1'b0; cur_iv = 1'b1; cur_a = 9; cur_b = 9; cur_c = 9;
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_nv_s", bus_s.out_valid, 0);
      check_val("stall_nv_w", bus_w.out_valid, 0);
    end
    wait_both("stall", 7, 7, 0, 0);

    // Asynchronous reset in the middle of a block.
    issue(1, 1, 0, 50, 3'b100);
    issue(1, 1, 0, 0, 3'b100);
    go_idle();
    for (int i = 0; i < 5; i++) step();
    check_val("pre_rst_p", bus_s.p, 52);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_p_s", bus_s.p, 0);
    check_val("rst_p_w", bus_w.p, 0);
    check_val("rst_valid", bus_s.out_valid, 0);
    check_val("rst_ovf", bus_s.ovf, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) issue(1, 1, 0, 0, 3'b100);
    wait_both("post_rst", 4, 4, 1, 0);

    // Randomised stream with stalls, flushes and near-range biases.
    for (int n = 0; n < 1500; n++) begin
      ra = AW'($urandom);
      rb = BW'($urandom);
      rd = BW'($urandom);
      case ($urandom_range(0, 3))
        0: cur_c = PMax - longint'($urandom_range(0, 1 << 20));
        1: cur_c = PMin + longint'($urandom_range(0, 1 << 20));
        2: begin rc = PW'({$urandom, $urandom}); cur_c = rc; end
        default: cur_c = longint'($urandom_range(0, 2000)) - 1000;
      endcase
      cur_a    = ra;
      cur_b    = rb;
      cur_d    = rd;
      cur_mode = 3'($urandom);
      if ($urandom_range(0, 9) < 6) cur_mode[2] = 1'b1;
      cur_ce  = ($urandom_range(0, 9) != 0);
      cur_clr = ($urandom_range(0, 39) == 0);
      cur_iv  = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end

    go_idle();
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_mac_slice.md
Name: dsp_mac_slice

Overview:
Parametrised, signed successor to the team's fixed 18x18 DSP slice. Datapath: input registers, then a pre-adder, then a multiplier, then a post-adder/accumulator. The widths, multiplier pipelining, accumulation length and saturation are all configurable. Adds three things the earlier slice lacks: a valid-qualified pipeline, accumulate-and-dump over a fixed sample count with a last flag, and overflow detection with optional saturation. Sits in filter/MAC datapaths, driven by a sample stream.

Parameters:
A_WIDTH, 18, signed width of A.
B_WIDTH, 18, signed width of B and D.
P_WIDTH, 48, signed width of C and P. Must be >= A_WIDTH+B_WIDTH+1; out-of-range values are a fatal elaboration error.
MREG, 1, multiplier output register present (1) or bypassed (0).
ACC_LEN, 16, number of samples per accumulate block (>=2).
SATURATE, 1, 1 = clamp P on overflow; 0 = two's-complement wrap.

Ports:
CLK  input  1  clock; all registers on rising edge.
RST_N  input  1  asynchronous active-low reset.
CE  input  1  pipeline enable; 0 = stall.
CLR  input  1  synchronous flush; priority over CE.
IN_VALID  input  1  sample on A/B/D/C/MODE is valid this cycle.
A  input  A_WIDTH  signed multiplicand.
B  input  B_WIDTH  signed pre-adder operand / multiplicand.
D  input  B_WIDTH  signed pre-adder operand.
C  input  P_WIDTH  signed post-adder addend / block bias.
MODE  input  3  [0] PRESUB (0: D+B, 1: D-B); [1] USE_PREADD (0: multiplier takes B); [2] ACC (accumulate-and-dump).
P  output  P_WIDTH  signed result, registered.
OUT_VALID  output  1  P holds a new result this cycle (single-cycle pulse).
OUT_LAST  output  1  result closes an accumulate block.
OVF  output  1  overflow occurred for this result (sticky across an accumulate block).

Behaviour:
- Reset (RST_N=0, async): every register clears to 0, including P, OUT_VALID, OUT_LAST, OVF, valid bits, block counter and stored MODE.
- Stage 1 registers A, B, D, C, MODE and IN_VALID. Stage 2 registers the pre-adder result, B_WIDTH+1 bits sign-extended, no truncation. If USE_PREADD=0, stage 2 registers sign-extended B.
- Stage 3 forms the signed product, A_WIDTH+B_WIDTH+1 bits; it is registered when MREG=1 and combinational when MREG=0.
- Stage 4 is the post-adder, which updates P.
- Latency from an accepted sample to OUT_VALID is 3+MREG enabled cycles. MODE and C travel with their sample, so per-sample mode changes are legal.
- CE=0: all data, valid and counter registers hold. IN_VALID is ignored and that sample is lost. OUT_VALID and OUT_LAST are forced 0; P and OVF hold.
- CLR=1: all in-flight valid bits, the block counter, OUT_VALID, OUT_LAST and OVF clear next edge. P clears to 0.
- Non-accumulate sample (ACC=0): P = M + C. OUT_VALID=1, OUT_LAST=0. OVF reflects this sum only.
- Accumulate sample (ACC=1) uses counter cnt in 0..ACC_LEN-1:
  - cnt=0: acc = M + C (C is the block bias); OVF restarts.
  - cnt>0: acc = acc + M; C is ignored.
  - cnt<ACC_LEN-1: cnt increments, OUT_VALID=0, and P shows the running sum.
  - cnt=ACC_LEN-1: OUT_VALID=1, OUT_LAST=1, cnt wraps to 0.
- An ACC=0 sample arriving while cnt!=0 aborts the block: the partial sum is discarded, cnt resets to 0, and the sample is handled as a non-accumulate sample.
- Overflow: the sum is computed at P_WIDTH+1 bits. It overflows if the result lies outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]. On overflow:
  - SATURATE=1: P clamps to the nearest bound.
  - SATURATE=0: P takes the low P_WIDTH bits.
  - In both cases OVF=1. In accumulate mode OVF is sticky until the next block start and is valid when OUT_LAST=1.
  - With saturation, later steps add to the clamped value.
- Reset or CLR mid-block discards the block; the next ACC=1 sample starts at cnt=0.

Test Plan:
- Default params, MODE=000, A=3, B=4, C=10, one valid cycle -> 4 cycles later P=22, OUT_VALID=1 for exactly one cycle, OUT_LAST=0, OVF=0.
- MODE=011, D=10, B=4, A=-2, C=0 -> P=-12. Then MODE=010 with the same inputs -> P=-28.
- ACC_LEN=4, MODE=100, B=1, C=100, A=1,2,3,4 on consecutive cycles -> OUT_VALID only on the 4th result, P=110, OUT_LAST=1. An immediate second block A=1,1,1,1, C=0 -> P=4.
- SATURATE=1, C=2^47-1, A=1, B=1, MODE=000 -> P=2^47-1, OVF=1. With SATURATE=0 -> P=-2^47, OVF=1.
- ACC_LEN=4: two ACC samples, then one ACC=0 sample (A=5, B=1, C=0) -> single result P=5, OUT_LAST=0. A following 4-sample block sums from zero plus its own bias.
- CE held 0 for 3 cycles mid-stream -> no OUT_VALID while stalled, results resume in order with no loss or duplication. RST_N pulsed low mid-block -> P=0, flags 0 asynchronously, cnt restarts at 0.
